// File: rtl/algo_16m8d_ma_prefetch.sv
// algo_16m8d_ma_prefetch: per-client malloc prefetch FIFO in front of one allocator malloc port
module algo_16m8d_ma_prefetch #(
  parameter int BITADDR = 14,
  parameter int DEPTH   = 8,
  parameter int BITDPTH = 3,
  parameter int LOWMARK = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alloc_ready,
  output logic               ma_write,
  input  logic               ma_bp,
  input  logic               ma_vld,
  input  logic [BITADDR-1:0] ma_adr,
  input  logic               ma_serr,
  input  logic               ma_derr,
  input  logic               cl_req,
  output logic               cl_rdy,
  output logic               cl_vld,
  output logic [BITADDR-1:0] cl_adr,
  output logic [BITDPTH:0]   fill,
  output logic [BITDPTH:0]   pend,
  output logic [7:0]         derr_cnt,
  output logic               serr_seen,
  output logic               underflow
);
  localparam int OW = BITDPTH + 2;
  localparam int FW = BITDPTH + 1;
  localparam logic [OW-1:0] DEPTH_W = OW'(DEPTH);
  localparam logic [OW-1:0] LOW_W   = OW'(LOWMARK);
  typedef enum logic {FILL, IDLE} state_t;
  state_t               state_q, state_d;
  logic [BITADDR-1:0]   mem_q [DEPTH];
  logic [BITDPTH-1:0]   wptr_q, rptr_q;
  logic [FW-1:0]        fill_q, fill_d, pend_q, pend_d;
  logic [OW-1:0]        occ, occ_nxt;
  logic [7:0]           derr_q;
  logic                 serr_q, unf_q, vld_q;
  logic [BITADDR-1:0]   adr_q;
  logic                 ret, push, drop, pop;
  // A return with nothing outstanding is ignored; stale returns never arrive since reset is shared.
  assign ret      = ma_vld & (pend_q != '0);
  assign push     = ret & ~ma_derr;
  assign drop     = ret & ma_derr;
  assign cl_rdy   = (fill_q != '0);
  assign pop      = cl_req & cl_rdy;
  assign occ      = OW'(fill_q) + OW'(pend_q);
  // rst gates the request so nothing is issued while the shared reset is held.
  assign ma_write = ~rst & (state_q == FILL) & alloc_ready & ~ma_bp & (occ < DEPTH_W);
  assign cl_vld    = vld_q;
  assign cl_adr    = adr_q;
  assign fill      = fill_q;
  assign pend      = pend_q;
  assign derr_cnt  = derr_q;
  assign serr_seen = serr_q;
  assign underflow = unf_q;
  // Next occupancy drives the refill hysteresis between LOWMARK and full.
  always_comb begin
    occ_nxt = occ + OW'(ma_write) - OW'(pop) - OW'(drop);
    state_d = occ_nxt < LOW_W ? FILL : occ_nxt == DEPTH_W ? IDLE : state_q;
    fill_d  = fill_q + FW'(push) - FW'(pop);
    pend_d  = pend_q + FW'(ma_write) - FW'(ret);
  end
  // State, pointers, counters and the registered pop output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      wptr_q  <= '0;
      rptr_q  <= '0;
      fill_q  <= '0;
      pend_q  <= '0;
      derr_q  <= '0;
      serr_q  <= 1'b0;
      unf_q   <= 1'b0;
      vld_q   <= 1'b0;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      pend_q  <= pend_d;
      vld_q   <= pop;
      if (push) wptr_q <= wptr_q + BITDPTH'(1);
      if (pop) rptr_q <= rptr_q + BITDPTH'(1);
      if (pop) adr_q <= mem_q[rptr_q];
      if (cl_req & ~cl_rdy) unf_q <= 1'b1;
      if (push & ma_serr) serr_q <= 1'b1;
      if (drop & (derr_q != 8'hff)) derr_q <= derr_q + 8'd1;
    end
  end
  // Address storage; contents are qualified by the pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= ma_adr;
  end
  ret_without_pend: assert property (@(posedge clk) disable iff (rst) !(ma_vld && pend_q == '0));
endmodule

// File: tb/tb_algo_16m8d_ma_prefetch.sv
// tb_algo_16m8d_ma_prefetch: scoreboard bench with a fixed-latency allocator model
module tb_algo_16m8d_ma_prefetch;
  localparam int BA = 14;
  logic clk = 0, rst = 1, alloc_ready = 1, ma_bp = 0, ma_vld = 0, ma_serr = 0, ma_derr = 0, cl_req = 0;
  logic [BA-1:0] ma_adr = '0;
  logic ma_write, cl_rdy, cl_vld, serr_seen, underflow;
  logic [BA-1:0] cl_adr;
  logic [3:0] fill, pend;
  logic [7:0] derr_cnt;
  int checks = 0, failures = 0;
  typedef struct { int due; logic [BA-1:0] adr; logic derr; logic serr; } ret_t;
  ret_t retq[$];
  logic [BA-1:0] exp_q[$];
  int cyc = 0, lat = 2, req_seq = 0, derr_seq = -1, serr_seq = -1;
  logic [BA-1:0] next_adr = 14'h010;

  algo_16m8d_ma_prefetch #(.BITADDR(BA), .DEPTH(8), .BITDPTH(3), .LOWMARK(4)) dut (
    .clk(clk), .rst(rst), .alloc_ready(alloc_ready), .ma_write(ma_write), .ma_bp(ma_bp),
    .ma_vld(ma_vld), .ma_adr(ma_adr), .ma_serr(ma_serr), .ma_derr(ma_derr),
    .cl_req(cl_req), .cl_rdy(cl_rdy), .cl_vld(cl_vld), .cl_adr(cl_adr),
    .fill(fill), .pend(pend), .derr_cnt(derr_cnt), .serr_seen(serr_seen), .underflow(underflow));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  // One clock cycle: drive the allocator return due now, log any request, predict pops, then compare pop output.
  task automatic step(output bit wr);
    ret_t r;
    bit got, pop_e;
    logic [BA-1:0] pa;
    got = retq.size() > 0 && retq[0].due == cyc;
    if (got) r = retq.pop_front();
    ma_vld  = got;
    ma_adr  = got ? r.adr : '0;
    ma_derr = got && r.derr;
    ma_serr = got && r.serr;
    #1;
    wr = ma_write;
    if (wr) begin
      req_seq++;
      retq.push_back('{due: cyc + lat, adr: next_adr, derr: req_seq == derr_seq, serr: req_seq == serr_seq});
      next_adr++;
    end
    pop_e = cl_req && exp_q.size() > 0;
    pa = '0;
    if (pop_e) pa = exp_q.pop_front();
    if (got && !r.derr) exp_q.push_back(r.adr);
    @(posedge clk); #1;
    cyc++;
    checks++;
    if (cl_vld !== pop_e) begin failures++; $display("FAIL pop_vld cyc=%0d got=%b exp=%b", cyc, cl_vld, pop_e); end
    if (pop_e) begin
      checks++;
      if (cl_adr !== pa) begin failures++; $display("FAIL pop_adr cyc=%0d got=%h exp=%h", cyc, cl_adr, pa); end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    @(posedge clk); #1;
    checks++;
    if ({ma_write, cl_rdy, cl_vld, cl_adr, fill, pend, derr_cnt, serr_seen, underflow} !== '0) begin
      failures++; $display("FAIL reset_vals got=%h exp=0", {ma_write, cl_rdy, cl_vld, cl_adr, fill, pend, derr_cnt, serr_seen, underflow});
    end
    rst = 0;
    cyc = 0;
  endtask

  task automatic test_cold_fill(input string tag);
    bit wr;
    int n = 0, first = -1, last = -1;
    for (int i = 0; i < 14; i++) begin
      step(wr);
      if (wr) begin if (first < 0) first = i; last = i; n++; end
    end
    checks++;
    if (n != 8 || first != 0 || last != 7) begin failures++; $display("FAIL %s_writes got n=%0d first=%0d last=%0d exp n=8 first=0 last=7", tag, n, first, last); end
    checks++;
    if (fill !== 4'd8 || pend !== 4'd0 || cl_rdy !== 1'b1) begin failures++; $display("FAIL %s_full got fill=%0d pend=%0d rdy=%b exp 8 0 1", tag, fill, pend, cl_rdy); end
  endtask

  task automatic test_drain_refill();
    bit wr;
    int n = 0, first = -1;
    cl_req = 1;
    for (int i = 0; i < 5; i++) begin step(wr); if (wr) n++; end
    cl_req = 0;
    checks++;
    if (n != 0) begin failures++; $display("FAIL drain_no_write got=%0d exp=0", n); end
    for (int i = 0; i < 12; i++) begin
      step(wr);
      if (wr) begin if (first < 0) first = i; n++; end
    end
    checks++;
    if (n != 5 || first != 0) begin failures++; $display("FAIL refill_writes got n=%0d first=%0d exp n=5 first=0", n, first); end
    checks++;
    if (fill !== 4'd8 || pend !== 4'd0) begin failures++; $display("FAIL refill_full got fill=%0d pend=%0d exp 8 0", fill, pend); end
  endtask

  task automatic test_backpressure();
    bit wr;
    int n = 0, first = -1;
    cl_req = 1;
    for (int i = 0; i < 5; i++) step(wr);
    cl_req = 0;
    ma_bp = 1;
    for (int i = 0; i < 4; i++) begin step(wr); if (wr) n++; end
    ma_bp = 0;
    checks++;
    if (n != 0) begin failures++; $display("FAIL bp_stall got writes=%0d exp=0", n); end
    for (int i = 0; i < 12; i++) begin
      step(wr);
      if (wr) begin if (first < 0) first = i; n++; end
    end
    checks++;
    if (n != 5 || first != 0) begin failures++; $display("FAIL bp_release got n=%0d first=%0d exp n=5 first=0", n, first); end
    checks++;
    if (fill !== 4'd8 || pend !== 4'd0) begin failures++; $display("FAIL bp_full got fill=%0d pend=%0d exp 8 0", fill, pend); end
  endtask

  task automatic test_error_return();
    bit wr;
    int n = 0;
    derr_seq = req_seq + 3;
    serr_seq = req_seq + 5;
    checks++;
    if (derr_cnt !== 8'd0 || serr_seen !== 1'b0) begin failures++; $display("FAIL err_pre got derr=%0d serr=%b exp 0 0", derr_cnt, serr_seen); end
    cl_req = 1;
    for (int i = 0; i < 5; i++) step(wr);
    cl_req = 0;
    for (int i = 0; i < 14; i++) begin step(wr); if (wr) n++; end
    checks++;
    if (n != 6) begin failures++; $display("FAIL err_writes got=%0d exp=6", n); end
    checks++;
    if (derr_cnt !== 8'd1 || serr_seen !== 1'b1) begin failures++; $display("FAIL err_flags got derr=%0d serr=%b exp 1 1", derr_cnt, serr_seen); end
    checks++;
    if (fill !== 4'd8 || pend !== 4'd0) begin failures++; $display("FAIL err_full got fill=%0d pend=%0d exp 8 0", fill, pend); end
  endtask

  task automatic test_empty_pop();
    bit wr;
    int n = 0;
    alloc_ready = 0;
    cl_req = 1;
    for (int i = 0; i < 8; i++) begin step(wr); if (wr) n++; end
    checks++;
    if (n != 0 || underflow !== 1'b0 || cl_rdy !== 1'b0) begin failures++; $display("FAIL drain_all got writes=%0d unf=%b rdy=%b exp 0 0 0", n, underflow, cl_rdy); end
    step(wr);
    cl_req = 0;
    checks++;
    if (underflow !== 1'b1 || fill !== 4'd0) begin failures++; $display("FAIL empty_pop got unf=%b fill=%0d exp 1 0", underflow, fill); end
  endtask

  task automatic test_back_to_back();
    bit wr;
    int n = 0, k = 0;
    alloc_ready = 1;
    for (int i = 0; i < 5; i++) begin step(wr); if (wr) n++; end
    alloc_ready = 0;
    checks++;
    if (n != 5) begin failures++; $display("FAIL b2b_writes got=%0d exp=5", n); end
    while (exp_q.size() < 4 && k < 10) begin step(wr); k++; end
    checks++;
    if (fill !== 4'd4 || pend !== 4'd1) begin failures++; $display("FAIL b2b_pre got fill=%0d pend=%0d exp 4 1", fill, pend); end
    cl_req = 1;
    step(wr);
    cl_req = 0;
    checks++;
    if (fill !== 4'd4 || pend !== 4'd0) begin failures++; $display("FAIL b2b_same_cycle got fill=%0d pend=%0d exp 4 0", fill, pend); end
    cl_req = 1;
    for (int i = 0; i < 4; i++) step(wr);
    cl_req = 0;
    checks++;
    if (fill !== 4'd0) begin failures++; $display("FAIL b2b_drain got fill=%0d exp 0", fill); end
  endtask

  task automatic test_reset_mid_fill();
    bit wr;
    lat = 3;
    alloc_ready = 1;
    for (int i = 0; i < 5; i++) step(wr);
    checks++;
    if (fill !== 4'd2 || pend !== 4'd3) begin failures++; $display("FAIL mid_pre got fill=%0d pend=%0d exp 2 3", fill, pend); end
    rst = 1;
    ma_vld = 0; ma_derr = 0; ma_serr = 0; ma_adr = '0;
    retq.delete();
    exp_q.delete();
    lat = 2;
    next_adr = 14'h100;
    #1;
    checks++;
    if ({ma_write, cl_rdy, cl_vld, cl_adr, fill, pend, derr_cnt, serr_seen, underflow} !== '0) begin
      failures++; $display("FAIL mid_reset got %h exp 0", {ma_write, cl_rdy, cl_vld, cl_adr, fill, pend, derr_cnt, serr_seen, underflow});
    end
    @(posedge clk); #1;
    rst = 0;
    cyc = 0;
    test_cold_fill("refill_after_rst");
    cl_req = 1;
    for (int i = 0; i < 2; i++) step(wr);
    cl_req = 0;
  endtask

  initial begin
    test_reset();
    test_cold_fill("cold");
    test_drain_refill();
    test_backpressure();
    test_error_return();
    test_empty_pop();
    test_back_to_back();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/algo_16m8d_ma_prefetch.md
# algo_16m8d_ma_prefetch

Per-client malloc prefetch buffer that sits directly downstream of one malloc port of the 16m8d allocator top. It issues single-cycle malloc requests (`ma_write`) and captures the returned addresses (`ma_vld`/`ma_adr`) into a small in-order FIFO. This lets a client pop a free address with fixed one-cycle latency, independent of allocator pipeline delay and backpressure. NUMMAPT copies are instantiated, one per malloc port.

## Interface
Parameters:
- BITADDR, 14, allocator address width
- DEPTH, 8, prefetch FIFO entries (power of two)
- BITDPTH, 3, log2(DEPTH)
- LOWMARK, 4, refill starts when occupancy drops below this (1..DEPTH)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- alloc_ready  in  1  allocator `ready`; no requests issued while low
- ma_write  out  1  malloc request to allocator port
- ma_bp  in  1  allocator backpressure for this port
- ma_vld  in  1  returned address valid (in request order)
- ma_adr  in  BITADDR  returned address
- ma_serr  in  1  returned address had corrected single-bit error
- ma_derr  in  1  returned address uncorrectable; must be discarded
- cl_req  in  1  client pop request
- cl_rdy  out  1  FIFO non-empty
- cl_vld  out  1  popped address valid
- cl_adr  out  BITADDR  popped address
- fill  out  BITDPTH+1  FIFO entry count
- pend  out  BITDPTH+1  requests issued, not yet returned
- derr_cnt  out  8  dropped-address count, saturating at 255
- serr_seen  out  1  sticky: any serr return accepted
- underflow  out  1  sticky: cl_req while empty

## Operation
- occ = fill + pend; invariant occ <= DEPTH.
- States: FILL, IDLE. Reset state is FILL.
- Transition rule: next state = FILL if occ_nxt < LOWMARK; IDLE if occ_nxt == DEPTH; otherwise hold current state.
- occ_nxt = occ + ma_write - pop - drop.
- ma_write = (state==FILL) & alloc_ready & !ma_bp & (occ < DEPTH). This is combinational from registers plus ma_bp and alloc_ready. Each asserted cycle is one request; pend increments.
- Return with ma_vld & !ma_derr: ma_adr is pushed at the tail; pend-1, fill+1. If ma_serr is also high, set serr_seen.
- Return with ma_vld & ma_derr: the address is dropped; pend-1, derr_cnt+1 (saturating).
- pop = cl_req & cl_rdy. The head entry is removed; fill-1. Next cycle cl_vld=1 and cl_adr=head.
- cl_req while empty: no pop; next cycle cl_vld=0; underflow set.
- Push and pop in the same cycle: fill unchanged, order preserved. When empty, the pushed entry becomes poppable the following cycle; there is no bypass.
- ma_vld while pend==0 is a protocol error. Flag it with a simulation assertion; RTL ignores the return.
- Pointers are BITDPTH bits and wrap modulo DEPTH.

## Timing
- Reset values: ma_write=0 while rst is asserted; cl_rdy=0, cl_vld=0, cl_adr=0, fill=0, pend=0, derr_cnt=0, serr_seen=0, underflow=0. Pointers are 0.
- First ma_write occurs in the first cycle after rst deasserts, provided alloc_ready=1 and ma_bp=0.
- Steady-state issue rate is one request per cycle; ma_bp stalls issue with zero-cycle response.
- Pop latency: cl_req at cycle N gives cl_vld/cl_adr at N+1. cl_rdy updates the cycle after push/pop.
- Reset mid-operation clears all state, including pend. Reset is shared with the allocator, so no stale returns arrive after reset.

## Test plan
- Cold fill (DEPTH=8, LOWMARK=4): allocator returns 0x010..0x017 two cycles after each request. Required: exactly 8 consecutive ma_write pulses, then stop; fill=8, pend=0, state IDLE, cl_rdy=1.
- Drain/refill: 5 back-to-back pops. Required: cl_adr=0x010..0x014 on cycles N+1..N+5. Refill starts once occ=3, then 5 more requests until occ=8.
- Backpressure: hold ma_bp=1 for 4 cycles during FILL. Required: ma_write=0 in exactly those cycles, no loss; fill reaches 8 after release.
- Error return: the 3rd return carries ma_derr=1, the 5th carries ma_serr=1. Required: 3rd address never popped; derr_cnt=1; serr_seen=1; one extra request issued; final fill=8.
- Empty pop and simultaneous events: cl_req with fill=0 gives cl_vld=0 and underflow=1. Pop and return in the same cycle at fill=4 gives fill=4 and order preserved.
- Reset mid-fill: assert rst with pend=3, fill=2. Required: all outputs at reset values immediately; clean cold fill after release.
